busytone_sched: RTL and testbench
=================================

Name: busytone_sched

Overview:
- Schedules busytone transmissions for the LoRa busytone RFNoC block. On a packet-detect strobe from the receive chain, it waits a programmable delay and then issues one 32-bit trigger word on an AXI-Stream interface to the busytone generator's trigger input.
- It then waits for the generator's end-of-tone indication, with a timeout, and enforces a holdoff before re-arming.
- It keeps saturating statistics for host readback. It sits between the settings-register / readback logic and the busytone generator, in the ce_clk domain.

Parameters:
- CNT_W, 24, width of the delay, holdoff and timeout counters and their config inputs.

Ports:
- ce_clk  input  1  block clock.
- ce_rst  input  1  synchronous active-high reset.
- enable  input  1  arms the scheduler; detects are ignored while low.
- detect_stb  input  1  single-cycle packet-detect strobe.
- detect_tag  input  16  tag latched with detect_stb (e.g. channel/SF code).
- cfg_word  input  16  upper half of the trigger word.
- cfg_delay  input  CNT_W  cycles from detect to trigger.
- cfg_holdoff  input  CNT_W  cycles after tone end before re-arming.
- cfg_tx_timeout  input  CNT_W  max cycles waiting for tone end; 0 disables the timeout.
- clear_stats  input  1  zeroes all statistics counters.
- trig_tdata  output  32  trigger word {cfg_word, tag}.
- trig_tvalid  output  1  AXIS valid.
- trig_tready  input  1  AXIS ready.
- tone_done  input  1  pulse, driven by the instantiating block from generator output tvalid&tready&tlast.
- busy  output  1  high whenever state is not IDLE.
- state_o  output  3  current state encoding.
- trig_count  output  16  triggers accepted by the generator.
- drop_count  output  16  detects received while busy.
- timeout_count  output  16  tone-end timeouts.

Behaviour:
- All outputs are registered.
- Reset (synchronous, ce_rst=1 at a rising edge):
  - state=IDLE; trig_tvalid=0; trig_tdata=0; busy=0.
  - All counters=0; internal timers=0; latched tag=0.
  - Reset mid-operation aborts any pending trigger, including one with tvalid high.
- State encoding: IDLE=0, DELAY=1, ISSUE=2, WAIT_DONE=3, HOLDOFF=4.
- IDLE:
  - If enable & detect_stb: latch detect_tag and load the timer with cfg_delay.
  - Next state is ISSUE if cfg_delay==0, else DELAY.
  - Detect at edge k gives trig_tvalid=1 from cycle k+1+cfg_delay.
- DELAY:
  - Timer decrements each cycle; go to ISSUE on the cycle it reaches 0. The state lasts exactly cfg_delay cycles.
  - enable=0 during DELAY returns to IDLE with no trigger and no counter change.
- ISSUE:
  - trig_tvalid=1; trig_tdata={cfg_word sampled on entry, latched tag}.
  - tvalid and tdata stay stable until trig_tvalid&trig_tready. enable changes do not drop tvalid.
  - On handshake: trig_count+1, load timer with cfg_tx_timeout, go to WAIT_DONE, and trig_tvalid=0 next cycle.
  - If trig_tready is already high on the first ISSUE cycle, the handshake completes in one cycle.
- WAIT_DONE:
  - tone_done=1: load timer with cfg_holdoff, go to HOLDOFF (or IDLE directly if cfg_holdoff==0).
  - Timeout enabled and timer reaches 0 without tone_done: timeout_count+1, same exit path.
  - tone_done on the timeout cycle counts as done; no timeout is counted.
  - Timeout disabled: wait indefinitely.
- HOLDOFF: lasts cfg_holdoff cycles, then IDLE. A detect is accepted on the first IDLE cycle.
- tone_done outside WAIT_DONE is ignored.
- detect_stb in any state other than IDLE: drop_count+1.
- detect_stb in IDLE with enable=0: ignored and not counted.
- Config sampling: cfg_delay at detect; cfg_word on ISSUE entry; cfg_tx_timeout at handshake; cfg_holdoff at WAIT_DONE exit. Mid-state config changes have no effect.
- Counters saturate at 16'hFFFF.
- clear_stats zeroes all three counters next cycle. Clear wins over a simultaneous increment. State is unaffected.
- busy and state_o reflect the registered state.

Test Plan:
- Basic sequence:
  - Stimulus: cfg_delay=5, cfg_word=16'hBEEF, tag=16'h0012, trig_tready=1, detect at edge k; tone_done 20 cycles after handshake; cfg_holdoff=3.
  - Required: tvalid high only at cycle k+6 with tdata=32'hBEEF0012; trig_count=1; IDLE reached 3 cycles after tone_done.
- Backpressure:
  - Stimulus: trig_tready low for 7 cycles after tvalid rises; toggle enable and detect_tag during the stall.
  - Required: tvalid and tdata constant throughout; exactly one handshake; trig_count=1.
- Timeout:
  - Stimulus: cfg_tx_timeout=10, no tone_done.
  - Required: timeout_count=1, HOLDOFF entered 10 cycles after handshake. Repeat with cfg_tx_timeout=0: remains in WAIT_DONE for 1000 cycles.
- Drops and abort:
  - Stimulus: 3 detects during WAIT_DONE/HOLDOFF; then a detect with cfg_delay=8 and enable dropped at the 4th DELAY cycle.
  - Required: drop_count=3; no trigger issued; state IDLE.
- Zero-delay and zero-holdoff:
  - Stimulus: cfg_delay=0, cfg_holdoff=0, tone_done pulse, detect on the next IDLE cycle.
  - Required: tvalid at k+1; second trigger accepted back-to-back.
- Saturation, clear and reset:
  - Stimulus: force 65536 drops; assert clear_stats coincident with a drop; assert ce_rst while tvalid=1.
  - Required: drop_count holds at FFFF; becomes 0 after the clear; after reset, tvalid=0 and state=IDLE on the next cycle.

Source files
------------

// File: rtl/busytone_sched.sv
// Busytone trigger scheduler: delays a packet-detect strobe, issues one AXIS
// trigger word to the busytone generator, then waits for tone end and holdoff.
module busytone_sched #(
  parameter int CNT_W = 24
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             enable,
  input  logic             detect_stb,
  input  logic [15:0]      detect_tag,
  input  logic [15:0]      cfg_word,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_holdoff,
  input  logic [CNT_W-1:0] cfg_tx_timeout,
  input  logic             clear_stats,
  output logic [31:0]      trig_tdata,
  output logic             trig_tvalid,
  input  logic             trig_tready,
  input  logic             tone_done,
  output logic             busy,
  output logic [2:0]       state_o,
  output logic [15:0]      trig_count,
  output logic [15:0]      drop_count,
  output logic [15:0]      timeout_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DELAY     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [15:0]      tag_q;
  logic             to_en;

  logic timer_last;
  logic trig_inc;
  logic drop_inc;
  logic to_inc;
  logic tone_exit;

  // state is itself a register, so state_o is a registered output
  assign state_o = state;

  // NOTE: every signal driven here gets a default first so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    timer_last = 1'b0;
    trig_inc   = 1'b0;
    drop_inc   = 1'b0;
    to_inc     = 1'b0;
    tone_exit  = 1'b0;
    timer_last = (timer == CNT_W'(1));
    trig_inc   = (state == ISSUE) && trig_tvalid && trig_tready;
    drop_inc   = detect_stb && (state != IDLE);
    tone_exit  = (state == WAIT_DONE) && (tone_done || (to_en && timer_last));
    // tone_done on the final timeout cycle counts as a normal completion
    to_inc     = (state == WAIT_DONE) && !tone_done && to_en && timer_last;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state       <= IDLE;
      timer       <= '0;
      tag_q       <= '0;
      to_en       <= 1'b0;
      trig_tvalid <= 1'b0;
      trig_tdata  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && detect_stb) begin
            tag_q <= detect_tag;
            timer <= cfg_delay;
            busy  <= 1'b1;
            if (cfg_delay == '0) begin
              state       <= ISSUE;
              trig_tvalid <= 1'b1;
              trig_tdata  <= {cfg_word, detect_tag};
            end else begin
              state <= DELAY;
            end
          end
        end

        DELAY: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer - CNT_W'(1);
            if (timer_last) begin
              state       <= ISSUE;
              trig_tvalid <= 1'b1;
              trig_tdata  <= {cfg_word, tag_q};
            end
          end
        end

        // tvalid/tdata hold until the handshake; enable is deliberately ignored
        ISSUE: begin
          if (trig_tready) begin
            state       <= WAIT_DONE;
            trig_tvalid <= 1'b0;
            timer       <= cfg_tx_timeout;
            to_en       <= (cfg_tx_timeout != '0);
          end
        end

        WAIT_DONE: begin
          if (tone_exit) begin
            timer <= cfg_holdoff;
            if (cfg_holdoff == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLDOFF;
            end
          end else if (to_en) begin
            timer <= timer - CNT_W'(1);
          end
        end

        HOLDOFF: begin
          timer <= timer - CNT_W'(1);
          if (timer_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          trig_tvalid <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Host statistics: saturating, and a clear overrides any same-cycle increment
  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear_stats) begin
      trig_count    <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (trig_inc) trig_count    <= sat_inc(trig_count);
      if (drop_inc) drop_count    <= sat_inc(drop_count);
      if (to_inc)   timeout_count <= sat_inc(timeout_count);
    end
  end

endmodule

// File: tb/tb_busytone_sched.sv
// Self-checking bench for busytone_sched: directed scenarios plus randomized
// transactions checked against a timeline model built from the block's rules.
module tb_busytone_sched;
  localparam int CNT_W = 24;

  logic             ce_clk = 1'b0;
  logic             ce_rst;
  logic             enable;
  logic             detect_stb;
  logic [15:0]      detect_tag;
  logic [15:0]      cfg_word;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_holdoff;
  logic [CNT_W-1:0] cfg_tx_timeout;
  logic             clear_stats;
  logic [31:0]      trig_tdata;
  logic             trig_tvalid;
  logic             trig_tready;
  logic             tone_done;
  logic             busy;
  logic [2:0]       state_o;
  logic [15:0]      trig_count;
  logic [15:0]      drop_count;
  logic [15:0]      timeout_count;

  int tests_run = 0;
  int fails     = 0;
  int exp_trig  = 0;
  int exp_drop  = 0;
  int exp_to    = 0;

  always #5 ce_clk = ~ce_clk;

  busytone_sched #(.CNT_W(CNT_W)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .enable(enable), .detect_stb(detect_stb),
    .detect_tag(detect_tag), .cfg_word(cfg_word), .cfg_delay(cfg_delay),
    .cfg_holdoff(cfg_holdoff), .cfg_tx_timeout(cfg_tx_timeout),
    .clear_stats(clear_stats), .trig_tdata(trig_tdata), .trig_tvalid(trig_tvalid),
    .trig_tready(trig_tready), .tone_done(tone_done), .busy(busy),
    .state_o(state_o), .trig_count(trig_count), .drop_count(drop_count),
    .timeout_count(timeout_count)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ce_clk);
      #1;
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic test_reset();
    ce_rst = 1'b1;
    tick(2);
    tests_run++; if (state_o !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_o); end
    tests_run++; if (trig_tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_valid_busy: got %b/%b want 0/0", trig_tvalid, busy); end
    tests_run++; if (trig_tdata !== 32'h0) begin fails++; $display("FAIL reset_tdata: got %h want 0", trig_tdata); end
    tests_run++; if (trig_count !== 16'h0 || drop_count !== 16'h0 || timeout_count !== 16'h0) begin
      fails++; $display("FAIL reset_counts: got %h/%h/%h want 0/0/0", trig_count, drop_count, timeout_count); end
    ce_rst = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int early;
    cfg_delay = 5; cfg_word = 16'hBEEF; cfg_holdoff = 3; cfg_tx_timeout = 0;
    trig_tready = 1'b1; detect_tag = 16'h0012;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    detect_tag = 16'h7777; cfg_delay = 9;
    early = int'(trig_tvalid);
    for (int i = 0; i < 4; i++) begin tick(); early += int'(trig_tvalid); end
    tests_run++; if (early != 0) begin fails++; $display("FAIL basic_early_valid: got %0d cycles want 0", early); end
    tick();
    tests_run++; if (trig_tvalid !== 1'b1) begin fails++; $display("FAIL basic_valid_at_delay: got %b want 1", trig_tvalid); end
    tests_run++; if (trig_tdata !== 32'hBEEF0012) begin fails++; $display("FAIL basic_tdata: got %h want BEEF0012", trig_tdata); end
    tick(); exp_trig = sat(exp_trig + 1);
    tests_run++; if (trig_tvalid !== 1'b0 || state_o !== 3'd3) begin fails++; $display("FAIL basic_handshake: got valid %b state %0d want 0/3", trig_tvalid, state_o); end
    tests_run++; if (trig_count !== 16'(exp_trig)) begin fails++; $display("FAIL basic_trig_count: got %0d want %0d", trig_count, exp_trig); end
    tick(19); tone_done = 1'b1; tick(); tone_done = 1'b0;
    tests_run++; if (state_o !== 3'd4) begin fails++; $display("FAIL basic_holdoff_entry: got %0d want 4", state_o); end
    tick(2);
    tests_run++; if (state_o !== 3'd4) begin fails++; $display("FAIL basic_holdoff_len: got %0d want 4", state_o); end
    tick();
    tests_run++; if (state_o !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL basic_idle_after_holdoff: got state %0d busy %b want 0/0", state_o, busy); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] held;
    logic stable;
    cfg_delay = 2; cfg_word = 16'hA5C3; detect_tag = 16'h1234; cfg_holdoff = 0;
    cfg_tx_timeout = 0; trig_tready = 1'b0;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    n = 0;
    while (!trig_tvalid && n < 20) begin tick(); n++; end
    tests_run++; if (n != 2) begin fails++; $display("FAIL bp_latency: got %0d want 2", n); end
    held = trig_tdata;
    tests_run++; if (held !== 32'hA5C31234) begin fails++; $display("FAIL bp_tdata: got %h want A5C31234", held); end
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enable = (i % 2) != 0; detect_tag = 16'($urandom); cfg_word = 16'($urandom);
      tick();
      if (trig_tvalid !== 1'b1 || trig_tdata !== held) stable = 1'b0;
    end
    tests_run++; if (!stable) begin fails++; $display("FAIL bp_stable: got %b %h want 1 %h", trig_tvalid, trig_tdata, held); end
    enable = 1'b1; trig_tready = 1'b1;
    tick(); exp_trig = sat(exp_trig + 1);
    tests_run++; if (trig_tvalid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop: got %b want 0", trig_tvalid); end
    tick(3);
    tests_run++; if (trig_count !== 16'(exp_trig) || state_o !== 3'd3) begin
      fails++; $display("FAIL bp_one_handshake: got count %0d state %0d want %0d/3", trig_count, state_o, exp_trig); end
    tone_done = 1'b1; tick(); tone_done = 1'b0;
    tests_run++; if (state_o !== 3'd0) begin fails++; $display("FAIL bp_zero_holdoff_idle: got %0d want 0", state_o); end
  endtask

  task automatic test_timeout();
    int cnt;
    cfg_delay = 1; cfg_holdoff = 2; cfg_tx_timeout = 10; trig_tready = 1'b1;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tick(2); exp_trig = sat(exp_trig + 1);
    cfg_tx_timeout = 3;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin tick(); if (state_o == 3'd3) cnt++; end
    tests_run++; if (cnt != 9) begin fails++; $display("FAIL to_wait_len: got %0d want 9", cnt); end
    tick(); exp_to = sat(exp_to + 1);
    tests_run++; if (state_o !== 3'd4) begin fails++; $display("FAIL to_holdoff_entry: got %0d want 4", state_o); end
    tests_run++; if (timeout_count !== 16'(exp_to)) begin fails++; $display("FAIL to_count: got %0d want %0d", timeout_count, exp_to); end
    tick(2);
    tests_run++; if (state_o !== 3'd0) begin fails++; $display("FAIL to_idle: got %0d want 0", state_o); end

    // tone end on the exact timeout cycle is a completion, not a timeout
    cfg_tx_timeout = 5;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tick(2); exp_trig = sat(exp_trig + 1);
    tick(4); tone_done = 1'b1; tick(); tone_done = 1'b0;
    tests_run++; if (state_o !== 3'd4 || timeout_count !== 16'(exp_to)) begin
      fails++; $display("FAIL to_done_same_cycle: got state %0d count %0d want 4/%0d", state_o, timeout_count, exp_to); end
    tick(2);

    cfg_tx_timeout = 0;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tick(2); exp_trig = sat(exp_trig + 1);
    cfg_tx_timeout = 7;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin tick(); if (state_o == 3'd3) cnt++; end
    tests_run++; if (cnt != 1000 || timeout_count !== 16'(exp_to)) begin
      fails++; $display("FAIL to_disabled: got %0d wait cycles count %0d want 1000/%0d", cnt, timeout_count, exp_to); end
    tone_done = 1'b1; tick(); tone_done = 1'b0;
    tick(2);
    tests_run++; if (state_o !== 3'd0 || trig_count !== 16'(exp_trig)) begin
      fails++; $display("FAIL to_disabled_exit: got state %0d trig %0d want 0/%0d", state_o, trig_count, exp_trig); end
  endtask

  task automatic test_drops_abort();
    int seen;
    cfg_delay = 0; cfg_holdoff = 4; cfg_tx_timeout = 0; trig_tready = 1'b1;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tick(); exp_trig = sat(exp_trig + 1);
    detect_stb = 1'b1; tick(); detect_stb = 1'b0; tick();
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    exp_drop = sat(exp_drop + 2);
    tone_done = 1'b1; tick(); tone_done = 1'b0;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    exp_drop = sat(exp_drop + 1);
    tick(3);
    tests_run++; if (state_o !== 3'd0) begin fails++; $display("FAIL drop_idle: got %0d want 0", state_o); end
    tests_run++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL drop_count: got %0d want %0d", drop_count, exp_drop); end

    enable = 1'b0;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tests_run++; if (state_o !== 3'd0 || drop_count !== 16'(exp_drop)) begin
      fails++; $display("FAIL disabled_detect: got state %0d drops %0d want 0/%0d", state_o, drop_count, exp_drop); end

    enable = 1'b1; cfg_delay = 8;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tick(3); enable = 1'b0; tick();
    tests_run++; if (state_o !== 3'd0) begin fails++; $display("FAIL abort_state: got %0d want 0", state_o); end
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); seen += int'(trig_tvalid); end
    tests_run++; if (seen != 0 || trig_count !== 16'(exp_trig) || drop_count !== 16'(exp_drop)) begin
      fails++; $display("FAIL abort_no_trigger: got valid %0d trig %0d drops %0d want 0/%0d/%0d", seen, trig_count, drop_count, exp_trig, exp_drop); end
  endtask

  task automatic test_zero_delay();
    cfg_delay = 0; cfg_holdoff = 0; cfg_tx_timeout = 0; trig_tready = 1'b1;
    cfg_word = 16'h0F0F; detect_tag = 16'h00AA;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tests_run++; if (trig_tvalid !== 1'b1 || trig_tdata !== 32'h0F0F00AA) begin
      fails++; $display("FAIL zero_first: got %b %h want 1 0F0F00AA", trig_tvalid, trig_tdata); end
    tick(); exp_trig = sat(exp_trig + 1);
    tone_done = 1'b1; tick(); tone_done = 1'b0;
    tests_run++; if (state_o !== 3'd0) begin fails++; $display("FAIL zero_holdoff_idle: got %0d want 0", state_o); end
    detect_tag = 16'h00BB;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tests_run++; if (trig_tvalid !== 1'b1 || trig_tdata !== 32'h0F0F00BB) begin
      fails++; $display("FAIL zero_back_to_back: got %b %h want 1 0F0F00BB", trig_tvalid, trig_tdata); end
    tick(); exp_trig = sat(exp_trig + 1);
    tests_run++; if (trig_count !== 16'(exp_trig)) begin fails++; $display("FAIL zero_trig_count: got %0d want %0d", trig_count, exp_trig); end
    tone_done = 1'b1; tick(); tone_done = 1'b0;
  endtask

  // Each transaction's timeline is predicted from the delay, stall, tone and
  // holdoff choices; detects injected while busy must all land in drop_count.
  task automatic test_random();
    int d, h, t, tt, s, n, wexit, wcnt, hcnt;
    logic [15:0] tag, word;
    logic tone, to_wins, stable;
    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, 6); h = $urandom_range(0, 5); s = $urandom_range(0, 4);
      tt = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 12);
      t = $urandom_range(1, 15); tone = ($urandom_range(0, 3) != 0) || (tt == 0);
      tag = 16'($urandom); word = 16'($urandom);
      cfg_delay = d; cfg_word = word; detect_tag = tag; trig_tready = (s == 0);
      detect_stb = 1'b1; tick(); detect_stb = 1'b0;
      cfg_delay = $urandom_range(0, 6); detect_tag = 16'($urandom);
      n = 0;
      while (!trig_tvalid && n < 40) begin
        detect_stb = $urandom_range(0, 1); if (detect_stb) exp_drop = sat(exp_drop + 1);
        tick(); n++;
      end
      detect_stb = 1'b0;
      tests_run++; if (n != d) begin fails++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, n, d); end
      tests_run++; if (trig_tdata !== {word, tag}) begin fails++; $display("FAIL rnd_tdata[%0d]: got %h want %h", it, trig_tdata, {word, tag}); end
      cfg_word = 16'($urandom);
      stable = 1'b1;
      for (int c = 0; c < s; c++) begin
        detect_stb = $urandom_range(0, 1); if (detect_stb) exp_drop = sat(exp_drop + 1);
        tick();
        if (trig_tvalid !== 1'b1 || trig_tdata !== {word, tag}) stable = 1'b0;
      end
      cfg_tx_timeout = tt; trig_tready = 1'b1;
      detect_stb = $urandom_range(0, 1); if (detect_stb) exp_drop = sat(exp_drop + 1);
      tick(); exp_trig = sat(exp_trig + 1);
      cfg_tx_timeout = $urandom_range(0, 12);
      tests_run++; if (!stable || trig_tvalid !== 1'b0) begin fails++; $display("FAIL rnd_stall[%0d]: got stable %b valid %b want 1/0", it, stable, trig_tvalid); end

      to_wins = (tt != 0) && (!tone || t > tt);
      wexit = to_wins ? tt : t;
      if (to_wins) exp_to = sat(exp_to + 1);
      cfg_holdoff = h;
      wcnt = 0;
      for (int c = 1; c <= wexit; c++) begin
        tone_done = tone && (c == t);
        detect_stb = $urandom_range(0, 1); if (detect_stb) exp_drop = sat(exp_drop + 1);
        if (state_o == 3'd3) wcnt++;
        tick();
      end
      tone_done = 1'b0; detect_stb = 1'b0; cfg_holdoff = $urandom_range(0, 5);
      tests_run++; if (wcnt != wexit) begin fails++; $display("FAIL rnd_wait_len[%0d]: got %0d want %0d", it, wcnt, wexit); end
      tests_run++; if (state_o !== ((h == 0) ? 3'd0 : 3'd4)) begin fails++; $display("FAIL rnd_exit_state[%0d]: got %0d want %0d", it, state_o, (h == 0) ? 0 : 4); end
      hcnt = 0;
      for (int c = 1; c <= h; c++) begin
        detect_stb = $urandom_range(0, 1); if (detect_stb) exp_drop = sat(exp_drop + 1);
        if (state_o == 3'd4) hcnt++;
        tick();
      end
      detect_stb = 1'b0;
      tests_run++; if (state_o !== 3'd0 || hcnt != h) begin fails++; $display("FAIL rnd_holdoff[%0d]: got state %0d len %0d want 0/%0d", it, state_o, hcnt, h); end
      tests_run++; if (trig_count !== 16'(exp_trig) || drop_count !== 16'(exp_drop) || timeout_count !== 16'(exp_to)) begin
        fails++; $display("FAIL rnd_counts[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", it, trig_count, drop_count, timeout_count, exp_trig, exp_drop, exp_to); end
    end
  endtask

  task automatic test_sat_clear_reset();
    cfg_delay = 0; cfg_holdoff = 0; cfg_tx_timeout = 0; trig_tready = 1'b1;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tick(); exp_trig = sat(exp_trig + 1);
    detect_stb = 1'b1;
    tick(65540); exp_drop = sat(exp_drop + 65540);
    tests_run++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL sat_drop: got %h want %h", drop_count, exp_drop); end
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    exp_trig = 0; exp_drop = 0; exp_to = 0;
    tests_run++; if (trig_count !== 16'h0 || drop_count !== 16'h0 || timeout_count !== 16'h0) begin
      fails++; $display("FAIL clear_counts: got %h/%h/%h want 0/0/0", trig_count, drop_count, timeout_count); end
    tests_run++; if (state_o !== 3'd3) begin fails++; $display("FAIL clear_keeps_state: got %0d want 3", state_o); end
    detect_stb = 1'b0;
    tone_done = 1'b1; tick(); tone_done = 1'b0;
    trig_tready = 1'b0;
    detect_stb = 1'b1; tick(); detect_stb = 1'b0;
    tests_run++; if (trig_tvalid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b want 1", trig_tvalid); end
    ce_rst = 1'b1; tick(); ce_rst = 1'b0;
    tests_run++; if (trig_tvalid !== 1'b0 || state_o !== 3'd0 || busy !== 1'b0 || trig_tdata !== 32'h0) begin
      fails++; $display("FAIL rst_abort: got valid %b state %0d busy %b tdata %h want 0/0/0/0", trig_tvalid, state_o, busy, trig_tdata); end
    trig_tready = 1'b1;
    tick(5);
    tests_run++; if (trig_tvalid !== 1'b0 || trig_count !== 16'h0) begin
      fails++; $display("FAIL rst_no_leftover: got valid %b trig %0d want 0/0", trig_tvalid, trig_count); end
  endtask

  initial begin
    ce_rst = 1'b1; enable = 1'b0; detect_stb = 1'b0; detect_tag = '0; cfg_word = '0;
    cfg_delay = '0; cfg_holdoff = '0; cfg_tx_timeout = '0; clear_stats = 1'b0;
    trig_tready = 1'b0; tone_done = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_drops_abort();
    test_zero_delay();
    test_random();
    test_sat_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
